// File: rtl/mem_bus_arbiter_pkg.sv
// Types and constants for the probe/CPU memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} arb_state_t;
  typedef enum logic {OWNER_PROBE, OWNER_CPU} bus_owner_t;

  localparam int unsigned ARB_MAX_READ_LATENCY = 3;
  localparam int unsigned ARB_RUN_CNT_W        = 4;

  // A transaction expects read data only when it reads and does not write.
  function automatic logic is_read(input logic mem_read, input logic we);
    return mem_read & ~we;
  endfunction

endpackage

// File: rtl/memory_bus_pkg.sv
// Shared memory-bus payload types used by every bus master and the slave decoder.
package MemoryBus;

  typedef struct packed {
    logic        mem_read;
    logic [3:0]  mask_byte;
    logic [31:0] write_data;
  } Cmd;

  typedef struct packed {
    logic [31:0] data;
  } Result;

endpackage

// File: rtl/mem_bus_arbiter_read_pipe.sv
// read_owner_pipe: {valid, owner} shift register tracking who owns each read in
// flight across the fixed slave latency.
//   clk, rst         clock, async active-high reset (discards in-flight reads)
//   in_valid/owner   read accepted this cycle and its master
//   out_valid/owner  read whose data is on the bus this cycle
//   cpu_pending      a CPU read is still in flight beyond this cycle
module read_owner_pipe
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  bus_owner_t in_owner,
  output logic       out_valid,
  output bus_owner_t out_owner,
  output logic       cpu_pending
);

  localparam int unsigned DEPTH_S = (DEPTH == 0) ? 1 : DEPTH;
  localparam int          LAST    = int'(DEPTH_S) - 1;

  logic [DEPTH_S-1:0] vld;
  logic [DEPTH_S-1:0] own_cpu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld     <= '0;
      own_cpu <= '0;
    end else begin
      vld[0]     <= in_valid;
      own_cpu[0] <= (in_owner == OWNER_CPU);
      for (int i = 1; i < int'(DEPTH_S); i++) begin
        vld[i]     <= vld[i-1];
        own_cpu[i] <= own_cpu[i-1];
      end
    end
  end

  // Zero latency bypasses the registers entirely.
  assign out_valid = (DEPTH == 0) ? in_valid : vld[LAST];
  assign out_owner = ((DEPTH == 0) ? (in_owner == OWNER_CPU) : own_cpu[LAST])
                     ? OWNER_CPU : OWNER_PROBE;

  // The exiting stage is excluded: its data is delivered this cycle.
  always_comb begin
    cpu_pending = 1'b0;
    for (int i = 0; i < LAST; i++) begin
      cpu_pending = cpu_pending | (vld[i] & own_cpu[i]);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the memory bus between the debug probe and the CPU
// data port with bounded probe priority, a drain-then-freeze halt mode, and
// read-data routing across a fixed slave latency.
//   probe_*  probe request/payload, halt request, ack, read response, halted flag
//   cpu_*    CPU request/payload, ack, read response, stall
//   mem_*    shared bus payload out, read data in
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W        = 30,
  parameter int unsigned READ_LATENCY  = 0,  // 0..ARB_MAX_READ_LATENCY
  parameter int unsigned MAX_PROBE_RUN = 4   // 1..15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                probe_req,
  input  logic [ADDR_W-1:0]   probe_address,
  input  logic                probe_we,
  input  MemoryBus::Cmd       probe_cmd,
  input  logic                probe_halt,
  output logic                probe_ack,
  output logic                probe_rvalid,
  output MemoryBus::Result    probe_result,
  output logic                probe_halted,
  input  logic                cpu_req,
  input  logic [ADDR_W-1:0]   cpu_address,
  input  logic                cpu_we,
  input  MemoryBus::Cmd       cpu_cmd,
  output logic                cpu_ack,
  output logic                cpu_rvalid,
  output MemoryBus::Result    cpu_result,
  output logic                cpu_stall,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_we,
  output MemoryBus::Cmd       mem_cmd,
  input  MemoryBus::Result    mem_result
);

  arb_state_t               state;
  logic [ARB_RUN_CNT_W-1:0] run_cnt;
  logic                     cpu_turn;
  logic                     grant_probe;
  logic                     grant_cpu;
  logic                     new_read;
  logic                     rd_valid;
  bus_owner_t               rd_owner;
  logic                     cpu_pending;
  MemoryBus::Result         probe_res_q;
  MemoryBus::Result         cpu_res_q;

  // Grant decision; the CPU only gets a slot in RUN, forced once the probe run saturates.
  always_comb begin
    grant_probe = 1'b0;
    grant_cpu   = 1'b0;
    cpu_turn    = (run_cnt == ARB_RUN_CNT_W'(MAX_PROBE_RUN));
    if (!rst) begin
      if (state == RUN) begin
        grant_cpu   = cpu_req & (~probe_req | cpu_turn);
        grant_probe = probe_req & ~grant_cpu;
      end else begin
        grant_probe = probe_req;
      end
    end
  end

  assign probe_ack = grant_probe;
  assign cpu_ack   = grant_cpu;

  // Shared bus payload mux; idle bus is all zeros.
  always_comb begin
    mem_address = '0;
    mem_we      = 1'b0;
    mem_cmd     = '0;
    if (grant_probe) begin
      mem_address = probe_address;
      mem_we      = probe_we;
      mem_cmd     = probe_cmd;
    end else if (grant_cpu) begin
      mem_address = cpu_address;
      mem_we      = cpu_we;
      mem_cmd     = cpu_cmd;
    end
  end

  assign cpu_stall    = rst ? 1'b0 : ((state == RUN) ? (cpu_req & ~grant_cpu) : 1'b1);
  assign probe_halted = (state == HALTED);

  // Arbitration state and consecutive-probe-grant counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      run_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (grant_cpu || !cpu_req) begin
            run_cnt <= '0;
          end else if (grant_probe) begin
            run_cnt <= run_cnt + ARB_RUN_CNT_W'(1);
          end
          if (probe_halt) state <= DRAIN;
        end
        DRAIN: begin
          run_cnt <= '0;
          if (!probe_halt) begin
            state <= RUN;
          end else if (!cpu_pending) begin
            state <= HALTED;
          end
        end
        HALTED: begin
          run_cnt <= '0;
          if (!probe_halt) state <= RUN;
        end
        default: begin
          state   <= RUN;
          run_cnt <= '0;
        end
      endcase
    end
  end

  assign new_read = (grant_probe & is_read(probe_cmd.mem_read, probe_we))
                  | (grant_cpu   & is_read(cpu_cmd.mem_read, cpu_we));

  read_owner_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_read_pipe (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (new_read),
    .in_owner   (grant_cpu ? OWNER_CPU : OWNER_PROBE),
    .out_valid  (rd_valid),
    .out_owner  (rd_owner),
    .cpu_pending(cpu_pending)
  );

  assign probe_rvalid = rd_valid & (rd_owner == OWNER_PROBE);
  assign cpu_rvalid   = rd_valid & (rd_owner == OWNER_CPU);

  // Each master's result holds the last data routed to it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      probe_res_q <= '0;
      cpu_res_q   <= '0;
    end else begin
      if (probe_rvalid) probe_res_q <= mem_result;
      if (cpu_rvalid)   cpu_res_q   <= mem_result;
    end
  end

  assign probe_result = probe_rvalid ? mem_result : probe_res_q;
  assign cpu_result   = cpu_rvalid   ? mem_result : cpu_res_q;

endmodule
